// File: rtl/pixel_fb_writer_pkg.sv
// Shared gpu line-drawing definitions: default geometry/widths,
// writer FSM encoding and a constant shift-add multiply helper.
package pixel_fb_writer_pkg;

   localparam int GPU_WIDTH   = 13;
   localparam int GPU_FB_W    = 640;
   localparam int GPU_FB_H    = 480;
   localparam int GPU_ADDR_W  = 19;
   localparam int GPU_COLOR_W = 8;
   localparam int GPU_DEPTH   = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } fb_state_e;

   // v * k for a constant k, built from shifted partial sums so
   // synthesis folds it into adders rather than a multiplier.
   function automatic logic [31:0] mul_const(
      input logic [31:0] v,
      input int          k
   );
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 31; i++) begin
         if (k[i]) acc = acc + (v << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/pix_wr_fifo.sv
// Write queue between address stage and memory port.
// Ports: clk/rst, push_i/wdata_i in, pop_i/rdata_o out (head,
// combinational), full_o/empty_o flags. Push while full is
// accepted only when a pop happens in the same cycle.
module pix_wr_fifo
   import pixel_fb_writer_pkg::*;
#(
   parameter int DEPTH = GPU_DEPTH,
   parameter int DW    = GPU_ADDR_W + GPU_COLOR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          do_push;
   logic          do_pop;

   // Extra pointer bit distinguishes full from empty.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                    (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/pixel_fb_writer.sv
// Pixel framebuffer writer: swaps/clips line pixels, forms a
// linear address, queues writes and drives a req/gnt memory port.
// Ports: pix_* handshake in, mem_req/gnt/addr/wdata out,
// busy/done line status, clip_cnt discarded-pixel counter.
module pixel_fb_writer
   import pixel_fb_writer_pkg::*;
#(
   parameter int WIDTH   = GPU_WIDTH,
   parameter int FB_W    = GPU_FB_W,
   parameter int FB_H    = GPU_FB_H,
   parameter int ADDR_W  = GPU_ADDR_W,
   parameter int COLOR_W = GPU_COLOR_W,
   parameter int DEPTH   = GPU_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [WIDTH-1:0]   pix_x,
   input  logic [WIDTH-1:0]   pix_y,
   input  logic [COLOR_W-1:0] pix_color,
   input  logic               steep,
   input  logic               pix_last,
   output logic               mem_req,
   input  logic               mem_gnt,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_wdata,
   output logic               busy,
   output logic               done,
   output logic [15:0]        clip_cnt
);

   localparam int DW = ADDR_W + COLOR_W;

   localparam logic signed [WIDTH-1:0] FBW_S = WIDTH'(FB_W);
   localparam logic signed [WIDTH-1:0] FBH_S = WIDTH'(FB_H);

   fb_state_e state_q, state_d;

   logic               s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
   logic [COLOR_W-1:0] s1_color_q, s1_color_d;
   logic [15:0]        clip_cnt_q, clip_cnt_d;

   logic signed [WIDTH-1:0] px, py;
   logic [ADDR_W-1:0]  px_u, py_u, addr_in;
   logic               clip_in;
   logic               accept;
   logic               in_line;
   logic               s1_adv;

   logic               fifo_full, fifo_empty;
   logic               fifo_pop;
   logic [DW-1:0]      fifo_rdata;

   // Coordinate swap for steep lines.
   assign px = $signed(steep ? pix_y : pix_x);
   assign py = $signed(steep ? pix_x : pix_y);

   assign clip_in = px[WIDTH-1] | py[WIDTH-1] |
                    (px >= FBW_S) | (py >= FBH_S);

   assign px_u = ADDR_W'($unsigned(px));
   assign py_u = ADDR_W'($unsigned(py));

   generate
      if (FB_W == 640) begin : g_w640
         assign addr_in = (py_u << 9) + (py_u << 7) + px_u;
      end else begin : g_wgen
         assign addr_in = ADDR_W'(mul_const(32'(py_u), FB_W))
                        + px_u;
      end
   endgenerate

   // Handshake: stage 1 frees up when empty or moving on.
   assign fifo_pop = mem_gnt & ~fifo_empty;
   assign s1_adv   = s1_valid_q & (~fifo_full | fifo_pop);
   assign in_line  = (state_q == ST_IDLE) |
                     (state_q == ST_ACTIVE);
   assign pix_ready = in_line & (~s1_valid_q | s1_adv);
   assign accept    = pix_valid & pix_ready;

   // Stage 1: clipped pixels never occupy the register.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_addr_d  = s1_addr_q;
      s1_color_d = s1_color_q;
      if (s1_adv) s1_valid_d = 1'b0;
      if (accept) begin
         s1_valid_d = ~clip_in;
         if (!clip_in) begin
            s1_addr_d  = addr_in;
            s1_color_d = pix_color;
         end
      end
   end

   // Counter restarts with each line, including its first pixel.
   always_comb begin
      clip_cnt_d = clip_cnt_q;
      if (accept && (state_q == ST_IDLE)) clip_cnt_d = '0;
      if (accept && clip_in && (clip_cnt_d != 16'hFFFF))
         clip_cnt_d = clip_cnt_d + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_color_q <= '0;
         clip_cnt_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_color_q <= s1_color_d;
         clip_cnt_q <= clip_cnt_d;
      end
   end

   assign clip_cnt = clip_cnt_q;

   pix_wr_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (s1_adv),
      .wdata_i ({s1_addr_q, s1_color_q}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Memory port mirrors the queue head, zero when idle.
   assign mem_req   = ~fifo_empty;
   assign mem_addr  = fifo_empty ? '0 : fifo_rdata[DW-1:COLOR_W];
   assign mem_wdata = fifo_empty ? '0 : fifo_rdata[COLOR_W-1:0];

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state; a one-pixel line goes straight to drain.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept)
               state_d = pix_last ? ST_DRAIN : ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (accept && pix_last) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!s1_valid_q && fifo_empty) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_ACTIVE, ST_DRAIN: busy = 1'b1;
         ST_DONE:             done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Self-checking bench for pixel_fb_writer: directed line scenarios
// plus random lines compared against a coordinate-level model.
module tb_pixel_fb_writer;

   localparam int AW = 19;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic [12:0]   pix_x = '0;
   logic [12:0]   pix_y = '0;
   logic [CW-1:0] pix_color = '0;
   logic          steep = 1'b0;
   logic          pix_last = 1'b0;
   logic          mem_req;
   logic          mem_gnt = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic [15:0]   clip_cnt;

   int checks = 0;
   int errors = 0;
   int exp_clip = 0;
   int gnt_mode = 0;
   logic gnt_level = 1'b0;

   logic [AW+CW-1:0] exp_q[$];
   logic [AW+CW-1:0] got_q[$];

   always #5 clk = ~clk;

   pixel_fb_writer dut (
      .clk       (clk),
      .rst       (rst),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_color (pix_color),
      .steep     (steep),
      .pix_last  (pix_last),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done),
      .clip_cnt  (clip_cnt)
   );

   // Grant driver: level, toggle or random.
   initial forever begin
      @(posedge clk);
      #1;
      case (gnt_mode)
         0:       mem_gnt = gnt_level;
         1:       mem_gnt = ~mem_gnt;
         default: mem_gnt = 1'($urandom_range(0, 1));
      endcase
   end

   // Write monitor: a write happens at the next rising edge.
   initial forever begin
      @(negedge clk);
      if (!rst && mem_req && mem_gnt)
         got_q.push_back({mem_addr, mem_wdata});
   end

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: framebuffer write implied by one pixel.
   task automatic record(input int x, input int y,
                         input logic [CW-1:0] c, input bit st);
      int fx, fy;
      fx = st ? y : x;
      fy = st ? x : y;
      if (fx >= 0 && fx < 640 && fy >= 0 && fy < 480)
         exp_q.push_back({AW'(fy * 640 + fx), c});
      else
         exp_clip++;
   endtask

   task automatic drive(input int x, input int y,
                        input logic [CW-1:0] c,
                        input bit st, input bit last);
      pix_valid = 1'b1;
      pix_x     = 13'(x);
      pix_y     = 13'(y);
      pix_color = c;
      steep     = st;
      pix_last  = last;
   endtask

   // Offer a pixel until accepted; returns just after the edge.
   task automatic send(input int x, input int y,
                       input logic [CW-1:0] c,
                       input bit st, input bit last);
      int n;
      n = 0;
      drive(x, y, c, st, last);
      forever begin
         @(negedge clk);
         if (pix_ready) break;
         n++;
         if (n > 200) break;
      end
      if (n > 200) begin
         check("accept_timeout", 32'(n), 32'd0);
      end else begin
         record(x, y, c, st);
      end
      step();
   endtask

   task automatic wait_done(output int ndone);
      int after;
      ndone = 0;
      after = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (done) ndone++;
         if (ndone > 0) begin
            after++;
            if (after > 4) break;
         end
      end
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_wr_count"}, 32'(got_q.size()),
            32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size()
                                        : exp_q.size();
      for (int i = 0; i < n; i++)
         check({tag, "_wr_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int nd, idx;
      int dx[8], dy[8];
      logic [CW-1:0] dc[8];

      // Reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req",   32'(mem_req),   32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_clip",  32'(clip_cnt),  32'd0);
      check("rst_addr",  32'(mem_addr),  32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(pix_ready), 32'd1);

      // A: plain pixel, latency and address.
      gnt_level = 1'b1;
      step();
      step();
      drive(10, 20, 8'h5A, 1'b0, 1'b1);
      @(negedge clk);
      check("A_ready", 32'(pix_ready), 32'd1);
      record(10, 20, 8'h5A, 1'b0);
      step();
      pix_valid = 1'b0;
      check("A_req_c1", 32'(mem_req), 32'd0);
      step();
      check("A_req_c2", 32'(mem_req),   32'd1);
      check("A_addr",   32'(mem_addr),  32'd12810);
      check("A_wdata",  32'(mem_wdata), 32'h5A);
      wait_done(nd);
      check("A_done", 32'(nd), 32'd1);
      compare_writes("A");

      // B: steep swap lands on the same address.
      step();
      send(20, 10, 8'hC3, 1'b1, 1'b1);
      pix_valid = 1'b0;
      wait_done(nd);
      check("B_done", 32'(nd), 32'd1);
      check("B_addr", (got_q.size() > 0) ? 32'(got_q[0][AW+CW-1:CW])
                                         : 32'hFFFF_FFFF, 32'd12810);
      compare_writes("B");

      // C: clipping boundaries.
      step();
      exp_clip = 0;
      send(-1, 5, 8'h11, 1'b0, 1'b0);
      send(640, 0, 8'h22, 1'b0, 1'b0);
      send(0, 480, 8'h33, 1'b0, 1'b0);
      send(639, 479, 8'h44, 1'b0, 1'b1);
      pix_valid = 1'b0;
      wait_done(nd);
      check("C_done", 32'(nd), 32'd1);
      check("C_clip", 32'(clip_cnt), 32'd3);
      check("C_addr", (got_q.size() > 0) ? 32'(got_q[0][AW+CW-1:CW])
                                         : 32'hFFFF_FFFF, 32'd307199);
      compare_writes("C");

      // D: back-pressure with grant held low.
      gnt_level = 1'b0;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         dx[i] = $urandom_range(0, 639);
         dy[i] = $urandom_range(0, 479);
         dc[i] = CW'($urandom);
      end
      idx = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (idx < 8) drive(dx[idx], dy[idx], dc[idx], 1'b0, idx == 7);
         else         pix_valid = 1'b0;
         @(negedge clk);
         if (pix_valid && pix_ready) begin
            record(dx[idx], dy[idx], dc[idx], 1'b0);
            idx++;
         end
         if (cyc == 9) begin
            check("D_accepted", 32'(idx),          32'd5);
            check("D_ready",    32'(pix_ready),    32'd0);
            check("D_nowrite",  32'(got_q.size()), 32'd0);
            gnt_level = 1'b1;
         end
         step();
         if (idx == 8) break;
      end
      pix_valid = 1'b0;
      check("D_all_acc", 32'(idx), 32'd8);
      wait_done(nd);
      check("D_done", 32'(nd), 32'd1);
      check("D_clip", 32'(clip_cnt), 32'd0);
      compare_writes("D");

      // E: reset with writes queued.
      gnt_level = 1'b0;
      step();
      step();
      for (int i = 0; i < 3; i++)
         send($urandom_range(0, 639), $urandom_range(0, 479),
              CW'($urandom), 1'b0, 1'b0);
      pix_valid = 1'b0;
      repeat (4) step();
      check("E_req_pre", 32'(mem_req), 32'd1);
      rst = 1'b1;
      #1;
      check("E_req",  32'(mem_req),  32'd0);
      check("E_busy", 32'(busy),     32'd0);
      check("E_clip", 32'(clip_cnt), 32'd0);
      check("E_addr", 32'(mem_addr), 32'd0);
      exp_q.delete();
      got_q.delete();
      gnt_level = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      check("E_ready", 32'(pix_ready), 32'd1);
      repeat (20) step();
      check("E_nowrite", 32'(got_q.size()), 32'd0);
      check("E_req_post", 32'(mem_req), 32'd0);

      // F: single last pixel, toggling grant.
      gnt_mode = 1;
      step();
      send($urandom_range(0, 639), $urandom_range(0, 479),
           CW'($urandom), 1'b0, 1'b1);
      pix_valid = 1'b0;
      check("F_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (got_q.size() > 0) break;
      end
      check("F_busy_wr", 32'(busy), 32'd1);
      wait_done(nd);
      check("F_done", 32'(nd), 32'd1);
      check("F_idle_busy",  32'(busy),      32'd0);
      check("F_idle_ready", 32'(pix_ready), 32'd1);
      compare_writes("F");

      // G: random lines with random grant.
      gnt_mode = 2;
      for (int r = 0; r < 3; r++) begin
         step();
         exp_clip = 0;
         for (int i = 0; i < 30; i++)
            send($urandom_range(0, 680) - 20,
                 $urandom_range(0, 520) - 20,
                 CW'($urandom), 1'($urandom_range(0, 1)),
                 i == 29);
         pix_valid = 1'b0;
         wait_done(nd);
         check("G_done", 32'(nd), 32'd1);
         check("G_clip", 32'(clip_cnt), 32'(exp_clip));
         compare_writes("G");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_fb_writer.md
PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 13, coordinate width (signed two's complement).
REQ-002 SHALL have parameter FB_W, default 640, framebuffer width in pixels.
REQ-003 SHALL have parameter FB_H, default 480, framebuffer height in pixels.
REQ-004 SHALL have parameter ADDR_W, default 19, memory word address width.
REQ-005 SHALL have parameter COLOR_W, default 8, pixel data width.
REQ-006 SHALL have parameter DEPTH, default 4, write-queue entries (power of two).
REQ-007 SHALL have ports clk input 1 system clock and rst input 1, with one clock; reset asynchronous and active-high.
REQ-008 SHALL have ports pix_valid input 1 (pixel offered), pix_ready output 1 (pixel accepted when both high).
REQ-009 SHALL have ports pix_x input WIDTH, pix_y input WIDTH, pix_color input COLOR_W, steep input 1 (swap x/y), pix_last input 1 (final pixel of line).
REQ-010 SHALL have ports mem_req output 1, mem_gnt input 1, mem_addr output ADDR_W, mem_wdata output COLOR_W.
REQ-011 SHALL have ports busy output 1, done output 1 (one-cycle pulse), clip_cnt output 16 (discarded-pixel count).

Function
REQ-012 SHALL accept a pixel on any rising clk edge with pix_valid and pix_ready high; pix_ready SHALL be high when the stage-1 register is empty or advancing into the queue.
REQ-013 SHALL, when steep=1, use (px,py)=(pix_y,pix_x); otherwise (px,py)=(pix_x,pix_y).
REQ-014 SHALL discard a pixel as clipped when px<0, py<0, px>=FB_W or py>=FB_H (signed compares).
REQ-015 SHALL increment clip_cnt by one per clipped pixel, saturating at 16'hFFFF.
REQ-016 SHALL register the result of stage 1 as address py*FB_W+px, truncated to ADDR_W, with no multiplier; shift-add only when FB_W=640 (py<<9 + py<<7 + px).
REQ-017 SHALL enqueue each unclipped stage-1 result into a DEPTH-entry FIFO one cycle after acceptance; minimum acceptance-to-mem_req latency is 2 cycles.
REQ-018 SHALL stall stage 1, with pix_ready low, while the FIFO is full and stage 1 holds an unclipped pixel.
REQ-019 SHALL drive mem_req high whenever the FIFO is non-empty, with mem_addr/mem_wdata equal to the head entry.
REQ-020 SHALL hold mem_addr/mem_wdata stable until mem_gnt is sampled high with mem_req, then pop exactly one entry.
REQ-021 SHALL support simultaneous enqueue and pop when full or empty without loss or duplication.
REQ-022 SHALL implement FSM IDLE->ACTIVE on first acceptance; ACTIVE->DRAIN when a pix_last pixel is accepted; DRAIN->DONE when stage 1 and FIFO are empty; DONE->IDLE next cycle.
REQ-023 SHALL treat pix_last on a clipped pixel identically: the line still completes.
REQ-024 SHALL deassert pix_ready in DRAIN and DONE.
REQ-025 SHALL pulse done for exactly one cycle in DONE; busy SHALL be high in ACTIVE and DRAIN.
REQ-026 SHALL clear clip_cnt on the IDLE->ACTIVE transition.

Reset
REQ-027 SHALL, on rst high regardless of clk, force FSM to IDLE, empty FIFO and stage 1, and drive mem_req=0, done=0, busy=0, clip_cnt=0, mem_addr=0, mem_wdata=0.
REQ-028 SHALL drop any in-flight write on reset mid-line, with no mem_req after release until new pixels arrive.
REQ-029 SHALL have pix_ready=1 in the first cycle after reset release.

Structure
REQ-030 SHALL take WIDTH, FB_W, FB_H, ADDR_W, COLOR_W and the FSM state encoding from the shared gpu line-drawing package.
REQ-031 SHALL contain one sub-module, pix_wr_fifo (parameterised DEPTH x (ADDR_W+COLOR_W), full/empty flags, async reset).

Verification
REQ-032 SHALL cover: pixel (10,20,color 8'h5A), steep=0, mem_gnt tied 1 -> mem_addr=12810, mem_wdata=8'h5A, mem_req two cycles after acceptance.
REQ-033 SHALL cover: (x=20,y=10), steep=1 -> mem_addr=12810.
REQ-034 SHALL cover: pixels (-1,5), (640,0), (0,480), (639,479, pix_last) -> clip_cnt=3, one write to addr 307199, done pulses once.
REQ-035 SHALL cover: 8 back-to-back pixels, mem_gnt low 10 cycles -> pix_ready low after queue+stage1 fill (5 accepted), all 8 written in order after gnt.
REQ-036 SHALL cover: rst asserted with 3 queued writes -> mem_req low same cycle, busy=0, no writes after release.
REQ-037 SHALL cover: single pixel with pix_last, mem_gnt pulsing every other cycle -> busy high until write, done one cycle, FSM back in IDLE.
